alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
Accumulator-based sequencer that sits directly upstream and downstream of the 8-bit ALU.
- Accepts 8-bit instructions over a valid/ready handshake and decodes them.
- Drives the ALU's OP, A and R inputs from its accumulator and an internal register file.
- Captures the ALU's OUT/CY back into the accumulator and carry flag.
- Provides immediate load, register store and carry clear locally, without the ALU.

Parameters:
- REG_AW, 3, register-file address width; 2**REG_AW registers of 8 bits; legal 1..4; index = instr[REG_AW-1:0].
- ACC_RST, 8'h00, accumulator reset value.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction/immediate byte valid.
- instr_ready  out  1  sequencer can accept a byte.
- instr  in  8  [7:4] opcode, [3:0] register index (low REG_AW bits used); in S_IMM the full byte is immediate data.
- alu_op  out  4  ALU OP; bit3 always 0.
- alu_a  out  8  ALU A operand = accumulator.
- alu_r  out  8  ALU R operand = regfile[ir index].
- alu_out  in  8  ALU result.
- alu_cy  in  1  ALU carry/borrow.
- acc  out  8  accumulator.
- cy  out  1  carry flag.
- done  out  1  one-cycle pulse when an instruction retires.

Behaviour:
- Opcodes:
  - 0x0 ADD, 0x1 SUB, 0x2 AND, 0x3 OR, 0x4 XOR, 0x5 NOT, 0x6 MOV: ALU class; alu_op = {1'b0, opcode[2:0]}.
  - 0x7 LDI: two-byte immediate load.
  - 0x8 STA: regfile[idx] <= acc.
  - 0x9 CLC: cy <= 0.
  - 0xA–0xF: NOP.
- States: S_IDLE, S_EXEC, S_IMM. instr_ready = (state != S_EXEC) && !rst. A transfer occurs on an edge with instr_valid && instr_ready.
- S_IDLE, transfer of:
  - ALU-class opcode: ir <= instr; go to S_EXEC.
  - LDI: go to S_IMM.
  - STA: regfile written at that edge; done=1 next cycle; stay in S_IDLE.
  - CLC: cy cleared at that edge; done=1 next cycle; stay in S_IDLE.
  - NOP: done=1 next cycle; stay in S_IDLE.
- S_EXEC (exactly 1 cycle):
  - alu_op, alu_a and alu_r are stable for the whole cycle; the ALU is combinational.
  - At the closing edge: acc <= alu_out; go to S_IDLE; done=1 in the following cycle.
  - Latency: instruction accepted at edge N, acc valid after edge N+1. Throughput is one ALU instruction per 2 cycles.
- Carry update at the S_EXEC closing edge:
  - ADD/SUB: cy <= alu_cy. SUB carry means borrow, i.e. A < R unsigned.
  - AND/OR/XOR/NOT: cy <= 0.
  - MOV: cy unchanged; alu_cy is ignored because the ALU does not drive it for MOV.
- S_IMM:
  - instr_ready=1. The next transfer loads acc <= instr (whole byte, no decode); cy unchanged; go to S_IDLE; done=1 next cycle.
  - No timeout; a stalled immediate waits indefinitely.
- Outside S_EXEC: alu_op and alu_r reflect the last ir (no glitch requirement); alu_a = acc at all times.
- Register file: combinational read, synchronous write. STA to the register currently addressed is visible on alu_r the cycle after the write.
- Back-pressure: instr_valid high during S_EXEC is not consumed; the byte must be held by the source and is accepted at the first S_IDLE edge.
- Reset (synchronous, overrides everything, including mid-S_EXEC and mid-S_IMM):
  - state=S_IDLE, acc=ACC_RST, cy=0, ir=0, all registers=0, done=0, alu_op=0.
  - The result of an in-flight S_EXEC is discarded.
  - A pending LDI immediate is abandoned; the next byte after reset is decoded as an opcode.
- Arithmetic: 8-bit modular; wrap-around is reported only through cy for ADD/SUB.

Test Plan:
- Reset → acc=0x00, cy=0, done=0, instr_ready=1 on the first cycle after rst drops.
- Carry case: LDI 0xF0, STA r1, LDI 0x20, ADD r1 → acc=0x10, cy=1. done pulses once per instruction; the ADD retires 2 cycles after acceptance.
- No-carry and borrow cases:
  - LDI 0x02, STA r2, LDI 0x0A, SUB r2 → acc=0x08, cy=0.
  - Then LDI 0x02, STA r3, LDI 0x0A, STA r2, LDI 0x02, SUB r2 → acc=0xF8, cy=1.
- Flag handling: with cy=1 from the borrow case, MOV r1 (r1=0xF0) → acc=0xF0, cy stays 1. Then XOR r1 → acc=0x00, cy=0. Then LDI 0xFF, ADD r1, CLC → cy=0.
- Back-pressure: hold instr_valid=1 with ADD then AND back-to-back → instr_ready=0 during S_EXEC; AND is accepted exactly one cycle later and neither instruction is lost or duplicated.
- Reset mid-operation:
  - Assert rst in S_IMM after LDI; release; send 0x21 → decoded as AND r1 (not an immediate) → acc=0x00.
  - Assert rst during S_EXEC of ADD → acc=ACC_RST, no done pulse.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// Accumulator sequencer wrapped around a combinational 8-bit ALU: decodes byte instructions,
// feeds the ALU from acc/regfile, retires results into acc/cy. One ALU op per 2 cycles; ready low in S_EXEC.
module alu_seq_ctrl #(
    parameter int         REG_AW  = 3,
    parameter logic [7:0] ACC_RST = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [7:0] instr,
    output logic [3:0] alu_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_r,
    input  logic [7:0] alu_out,
    input  logic       alu_cy,
    output logic [7:0] acc,
    output logic       cy,
    output logic       done
);

    localparam int NREG = 1 << REG_AW;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_IMM} state_t;

    state_t              state;
    logic [REG_AW-1:0]   ir_idx;
    logic [7:0]          regfile [NREG];
    logic                xfer;
    logic                is_alu;

    assign instr_ready = (state != S_EXEC) && !rst;
    assign xfer        = instr_valid && instr_ready;
    assign is_alu      = !instr[7] && (instr[6:4] != 3'b111);
    assign alu_a       = acc;
    assign alu_r       = regfile[ir_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            acc    <= ACC_RST;
            cy     <= 1'b0;
            ir_idx <= '0;
            alu_op <= 4'h0;
            done   <= 1'b0;
            for (int i = 0; i < NREG; i++) regfile[i] <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (xfer) begin
                        if (is_alu) begin
                            ir_idx <= instr[REG_AW-1:0];
                            alu_op <= {1'b0, instr[6:4]};
                            state  <= S_EXEC;
                        end else begin
                            case (instr[7:4])
                                4'h7: state <= S_IMM;
                                4'h8: begin
                                    regfile[instr[REG_AW-1:0]] <= acc;
                                    done <= 1'b1;
                                end
                                4'h9: begin
                                    cy   <= 1'b0;
                                    done <= 1'b1;
                                end
                                default: done <= 1'b1;
                            endcase
                        end
                    end
                end
                S_EXEC: begin
                    acc <= alu_out;
                    // MOV leaves carry alone: the ALU does not drive alu_cy for it
                    case (alu_op[2:0])
                        3'd0, 3'd1: cy <= alu_cy;
                        3'd6:       cy <= cy;
                        default:    cy <= 1'b0;
                    endcase
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                S_IMM: begin
                    if (xfer) begin
                        acc   <= instr;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl with a behavioural ALU and an instruction-level reference model.
module tb_alu_seq_ctrl;

    localparam logic [7:0] ACC_RST = 8'h00;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [7:0] instr = 8'h00;
    logic [3:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_r;
    logic [7:0] alu_out;
    logic       alu_cy;
    logic [7:0] acc;
    logic       cy;
    logic       done;

    alu_seq_ctrl #(.REG_AW(3), .ACC_RST(ACC_RST)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .alu_op(alu_op), .alu_a(alu_a), .alu_r(alu_r),
        .alu_out(alu_out), .alu_cy(alu_cy), .acc(acc), .cy(cy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU model; carry is random noise for ops whose carry the sequencer must ignore
    logic junk = 1'b0;
    always @(posedge clk) junk <= 1'($urandom);
    always_comb begin
        alu_out = 8'h00;
        alu_cy  = junk;
        case (alu_op)
            4'd0: {alu_cy, alu_out} = {1'b0, alu_a} + {1'b0, alu_r};
            4'd1: begin alu_out = alu_a - alu_r; alu_cy = (alu_a < alu_r); end
            4'd2: alu_out = alu_a & alu_r;
            4'd3: alu_out = alu_a | alu_r;
            4'd4: alu_out = alu_a ^ alu_r;
            4'd5: alu_out = ~alu_a;
            4'd6: alu_out = alu_r;
            default: alu_out = 8'h00;
        endcase
    end

    typedef struct { logic [7:0] acc; logic cy; int cyc; } exp_t;
    exp_t sbq[$];
    int total = 0;
    int bad = 0;

    logic [7:0] m_acc;
    logic       m_cy;
    logic [7:0] m_regs [8];
    bit         m_imm;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (done !== 1'b0) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL done_unexpected: got done=%b expected 0 (cycle %0d)", done, cyc);
            end else begin
                e = sbq.pop_front();
                chk("retire_acc", acc, e.acc);
                chk("retire_cy", cy, e.cy);
                chk("retire_cycle", cyc, e.cyc);
            end
        end
    end

    // Instruction-level reference: what each accepted byte does to acc/cy/regs
    task automatic model_accept(input logic [7:0] b, input int acyc);
        logic [7:0] r;
        logic [8:0] sum;
        r = m_regs[b[2:0]];
        if (m_imm) begin
            m_acc = b;
            m_imm = 0;
            sbq.push_back('{m_acc, m_cy, acyc});
        end else begin
            case (b[7:4])
                4'h0: begin sum = {1'b0, m_acc} + {1'b0, r}; m_acc = sum[7:0]; m_cy = sum[8]; end
                4'h1: begin m_cy = (m_acc < r); m_acc = m_acc - r; end
                4'h2: begin m_acc = m_acc & r; m_cy = 1'b0; end
                4'h3: begin m_acc = m_acc | r; m_cy = 1'b0; end
                4'h4: begin m_acc = m_acc ^ r; m_cy = 1'b0; end
                4'h5: begin m_acc = ~m_acc; m_cy = 1'b0; end
                4'h6: m_acc = r;
                4'h7: m_imm = 1;
                4'h8: m_regs[b[2:0]] = m_acc;
                4'h9: m_cy = 1'b0;
                default: ;
            endcase
            if (b[7:4] < 4'h7)
                sbq.push_back('{m_acc, m_cy, acyc + 1});
            else if (b[7:4] != 4'h7)
                sbq.push_back('{m_acc, m_cy, acyc});
        end
    endtask

    // Called and returns at a falling edge; valid stays high until the next action
    task automatic send_byte(input logic [7:0] b);
        int  waited = 0;
        int  acyc;
        bit  alu_cls;
        instr       = b;
        instr_valid = 1'b1;
        while (!instr_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!instr_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got ready=0 expected 1 within 50 cycles");
            instr_valid = 1'b0;
            return;
        end
        acyc    = cyc + 1;
        alu_cls = !m_imm && (b[7:4] < 4'h7);
        @(posedge clk);
        model_accept(b, acyc);
        @(negedge clk);
        if (alu_cls) chk("busy_ready", instr_ready, 0);
    endtask

    task automatic ldi(input logic [7:0] v);
        send_byte(8'h70);
        send_byte(v);
    endtask

    task automatic idle(input int n);
        instr_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        #1;
        instr_valid = 1'b0;
        rst = 1'b1;
        sbq.delete();
        m_acc = ACC_RST;
        m_cy  = 1'b0;
        m_imm = 0;
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_acc", acc, ACC_RST);
        chk("rst_cy", cy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready_low", instr_ready, 0);
        chk("rst_alu_op", alu_op, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", instr_ready, 1);
        @(negedge clk);
        chk("post_rst_done", done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int         r;
        do_reset();

        ldi(8'hF0); send_byte(8'h81); ldi(8'h20); send_byte(8'h01); idle(3);
        chk("carry_acc", acc, 8'h10);
        chk("carry_cy", cy, 1);

        ldi(8'h02); send_byte(8'h82); ldi(8'h0A); send_byte(8'h12); idle(3);
        chk("nocarry_acc", acc, 8'h08);
        chk("nocarry_cy", cy, 0);

        ldi(8'h02); send_byte(8'h83); ldi(8'h0A); send_byte(8'h82); ldi(8'h02); send_byte(8'h12); idle(3);
        chk("borrow_acc", acc, 8'hF8);
        chk("borrow_cy", cy, 1);

        send_byte(8'h61); idle(3);
        chk("mov_acc", acc, 8'hF0);
        chk("mov_cy", cy, 1);
        send_byte(8'h41); idle(3);
        chk("xor_acc", acc, 8'h00);
        chk("xor_cy", cy, 0);
        ldi(8'hFF); send_byte(8'h01); idle(2);
        chk("add_ff_cy", cy, 1);
        send_byte(8'h90); idle(2);
        chk("clc_cy", cy, 0);

        // back-to-back ALU ops with valid held through S_EXEC
        send_byte(8'h01); send_byte(8'h21); idle(3);

        send_byte(8'h70); do_reset(); send_byte(8'h21); idle(3);
        chk("rst_imm_and_acc", acc, 8'h00);

        ldi(8'h05); send_byte(8'h81); send_byte(8'h01); do_reset();
        chk("rst_exec_acc", acc, ACC_RST);

        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                do_reset();
            end else if (r < 15) begin
                idle(int'($urandom_range(1, 3)));
            end else begin
                b = 8'($urandom);
                send_byte(b);
                if (b[7:4] == 4'h7 && r > 20) send_byte(8'($urandom));
            end
        end
        if (m_imm) send_byte(8'($urandom));
        idle(5);
        chk("scoreboard_drained", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
